// File: rtl/dram_uart_tx_pkg.sv
// Shared types and constants for the DRAM-to-UART result upload engine.
package dram_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_DONE  = 3'd6
    } tx_state_t;

    localparam int DATA_BITS     = 8;
    // Cycles from accept (or address increment) to the start bit: address
    // registration plus the DRAM read.
    localparam int FETCH_LATENCY = 2;

    // Width of the baud counter; never narrower than one bit.
    function automatic int baud_cnt_width(input int clks_per_bit);
        if (clks_per_bit > 2) begin
            return $clog2(clks_per_bit);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_counter
    import dram_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Free-running period counter, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == TERMINAL) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign bit_done = (cnt_r == TERMINAL) && !clear;

endmodule

// File: rtl/dram_uart_tx.sv
// Reads a contiguous DRAM byte range and sends each byte as an 8N1 UART frame.
module dram_uart_tx
    import dram_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              begin_transmit,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       byte_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic              data_to_pc,
    output logic              busy,
    output logic              end_transmitting
);

    tx_state_t   state_r;
    logic [15:0] remaining_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_idx_r;
    logic        baud_clear_s;
    logic        bit_done_s;

    // The bit timer only runs while a frame is on the line.
    always_comb begin
        baud_clear_s = 1'b1;
        case (state_r)
            ST_START, ST_DATA, ST_STOP: baud_clear_s = 1'b0;
            default:                    baud_clear_s = 1'b1;
        endcase
    end

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear_s),
        .bit_done(bit_done_s)
    );

    // Transfer sequencer: owns the address, the byte count, the shift register
    // and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            mem_addr         <= {ADDR_W{1'b0}};
            remaining_r      <= 16'd0;
            shift_r          <= 8'd0;
            bit_idx_r        <= 3'd0;
            data_to_pc       <= 1'b1;
            busy             <= 1'b0;
            end_transmitting <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_to_pc       <= 1'b1;
                    end_transmitting <= 1'b0;
                    if (begin_transmit) begin
                        mem_addr    <= base_addr;
                        remaining_r <= byte_count;
                        busy        <= 1'b1;
                        state_r     <= (byte_count == 16'd0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_r    <= mem_q;
                    data_to_pc <= 1'b0;
                    state_r    <= ST_START;
                end
                ST_START: begin
                    if (bit_done_s) begin
                        data_to_pc <= shift_r[0];
                        shift_r    <= {1'b0, shift_r[7:1]};
                        bit_idx_r  <= 3'd0;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done_s) begin
                        if (bit_idx_r == 3'(DATA_BITS - 1)) begin
                            data_to_pc <= 1'b1;
                            state_r    <= ST_STOP;
                        end else begin
                            data_to_pc <= shift_r[0];
                            shift_r    <= {1'b0, shift_r[7:1]};
                            bit_idx_r  <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_done_s) begin
                        if (remaining_r == 16'd1) begin
                            remaining_r      <= 16'd0;
                            busy             <= 1'b0;
                            end_transmitting <= 1'b1;
                            state_r          <= ST_DONE;
                        end else begin
                            remaining_r <= remaining_r - 16'd1;
                            mem_addr    <= mem_addr + ADDR_W'(1);
                            state_r     <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    // A normal transfer raised the pulse on entry, so this
                    // clears it; a zero-length transfer arrives with it low
                    // and raises it here.
                    end_transmitting <= !end_transmitting;
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    data_to_pc       <= 1'b1;
                    busy             <= 1'b0;
                    end_transmitting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dram_uart_tx.md
# dram_uart_tx

Result-upload engine for the matrix-multiplication processor: after processing ends, it reads a contiguous range of bytes from the data memory (DRAM) and serialises each byte onto the PC-bound UART line (8N1, LSB first). It is the transmit counterpart of the PC-to-memory loader. `main_control` starts it with `begin_transmit` and waits for `end_transmitting` before returning to idle. It shares the DRAM read port with the processor; `main_control` status guarantees exclusive use while `busy` is high.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit; legal range ≥ 2.
- `ADDR_W`, default 16: DRAM address width.
- `clk` input 1: system clock, the divided `clock` of the top level.
- `rst` input 1: synchronous, active-high reset.
- `begin_transmit` input 1: start request, sampled only in IDLE, one cycle suffices.
- `base_addr` input ADDR_W: first DRAM byte address, latched on accept.
- `byte_count` input 16: number of bytes to send, latched on accept.
- `mem_addr` output ADDR_W: registered DRAM read address.
- `mem_q` input 8: DRAM read data, valid one cycle after the DRAM samples `mem_addr`.
- `data_to_pc` output 1: UART TX line, idle high.
- `busy` output 1: high from accept until the cycle `end_transmitting` asserts.
- `end_transmitting` output 1: one-cycle pulse when the last stop bit completes.

## Operation
- States are IDLE, FETCH, LOAD, START, DATA, STOP, DONE.
- IDLE → FETCH on `begin_transmit`:
  - latch `mem_addr`←`base_addr` and `remaining`←`byte_count`
  - set `busy`=1
  - if `byte_count`==0, go to DONE instead; no frame is sent.
- FETCH lasts 1 cycle and covers the DRAM address registration.
- LOAD lasts 1 cycle and captures `mem_q` into the 8-bit shift register.
- START holds `data_to_pc`=0 for CLKS_PER_BIT cycles.
- DATA drives 8 bits, bit 0 first, each held for CLKS_PER_BIT cycles.
- STOP holds `data_to_pc`=1 for CLKS_PER_BIT cycles, then decrements `remaining`:
  - if `remaining` is still nonzero, increment `mem_addr` and go to FETCH
  - otherwise go to DONE.
- DONE lasts 1 cycle: `end_transmitting`=1, `busy`=0, then IDLE.
- `mem_addr` increments modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
- `begin_transmit` outside IDLE is ignored. `base_addr` and `byte_count` changes after accept have no effect.
- `data_to_pc` is 1 in every state except START and the 0-bits of DATA.
- Reset in any state forces IDLE at the next edge, with no `end_transmitting` pulse. A partially sent frame is truncated and the line returns high.

## Timing
- Reset values: `data_to_pc`=1, `busy`=0, `end_transmitting`=0, `mem_addr`=0, all counters 0.
- Accept at edge E sets `mem_addr`=base and `busy`=1 at E.
- The start bit begins at edge E+2.
- Data bit i begins at E+2+(i+1)·C, where C=CLKS_PER_BIT.
- The stop bit begins at E+2+9C.
- The frame ends at E+2+10C. There:
  - last byte: `end_transmitting` rises for exactly one cycle and `busy` falls
  - otherwise: `mem_addr` increments.
- Frame-to-frame period is 10C+2 cycles, so the line stays high 2 extra cycles between frames.
- Total duration for N bytes: N·(10C+2) cycles from accept to `end_transmitting`.
- `byte_count`=0: `end_transmitting` at E+1, `busy` high for one cycle.
- A new `begin_transmit` may be accepted in the cycle after DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dram_uart_tx_pkg` holds:
  - state enum `tx_state_t`
  - constants `DATA_BITS`=8 and `FETCH_LATENCY`=2
  - helper constant for the bit-counter width, `$clog2(CLKS_PER_BIT)`.
- Sub-module `baud_counter`:
  - counts 0..CLKS_PER_BIT-1 with a synchronous clear
  - emits a `bit_done` pulse on the terminal count.
- The top FSM owns the address, the remaining count and the shift register.

## Test plan
Bench uses CLKS_PER_BIT=4 with a synchronous DRAM model of 1-cycle latency.
- **Single byte:** DRAM[0x0010]=0xA5, base 0x0010, count 1 → line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles long, start bit at E+2; `end_transmitting` one cycle at E+42.
- **Three bytes:** DRAM[0x20..0x22]=0x00,0xFF,0x3C, count 3 → three correct frames, 2 idle-high cycles between frames, `mem_addr` sequence 0x20,0x21,0x22, `end_transmitting` at E+126.
- **Address wrap:** base 0xFFFF, count 2 → reads 0xFFFF then 0x0000; both bytes correct.
- **Zero count:** count 0 → no line activity, `busy` high for one cycle, `end_transmitting` at E+1.
- **Ignored start:** `begin_transmit` pulsed again mid-frame → no restart and no effect on output.
- **Reset mid-frame:** `rst` during DATA bit 3 → next edge `data_to_pc`=1, `busy`=0, no `end_transmitting`; a fresh transfer afterwards works.
